// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the per-axis phase enumeration for the
// sync generator and the drawing blocks.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 800;
    localparam int unsigned H_FP_DEF     = 56;
    localparam int unsigned H_SYNC_DEF   = 120;
    localparam int unsigned H_BP_DEF     = 64;
    localparam int unsigned V_ACTIVE_DEF = 600;
    localparam int unsigned V_FP_DEF     = 37;
    localparam int unsigned V_SYNC_DEF   = 6;
    localparam int unsigned V_BP_DEF     = 23;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned HCNT_W = 12;
    localparam int unsigned VCNT_W = 11;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Exposes the next phase so the parent can register aligned outputs.
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned FP     = H_FP_DEF,
    parameter int unsigned SYNC   = H_SYNC_DEF,
    parameter int unsigned BP     = H_BP_DEF,
    parameter int unsigned CNT_W  = HCNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output phase_t           phase_nxt_c,
    output logic             wrap_c
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_TOTAL  = CNT_W'(TOTAL - 1);

    phase_t           phase;
    logic [CNT_W-1:0] count_nxt;

    assign wrap_c = en && (count == LAST_TOTAL);

    // Next position and phase; the phase moves on the edge the counter crosses a boundary
    always_comb begin
        count_nxt   = count;
        phase_nxt_c = phase;
        if (wrap_c) begin
            count_nxt   = '0;
            phase_nxt_c = PH_ACTIVE;
        end else if (en) begin
            count_nxt = count + CNT_W'(1);
            unique case (phase)
                PH_ACTIVE: if (count == LAST_ACTIVE) phase_nxt_c = PH_FRONT;
                PH_FRONT:  if (count == LAST_FRONT)  phase_nxt_c = PH_SYNC;
                PH_SYNC:   if (count == LAST_SYNC)   phase_nxt_c = PH_BACK;
                PH_BACK:   phase_nxt_c = PH_BACK;
                default:   phase_nxt_c = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else begin
            count <= count_nxt;
            phase <= phase_nxt_c;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: horizontal/vertical axis timers with all outputs
// registered so they describe the same (hcounter, vcounter) pair.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [HCNT_W-1:0] hcounter,
    output logic [VCNT_W-1:0] vcounter,
    output logic              visible,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              frame_start,
    output logic              line_start
);

    logic   run_q;
    logic   h_wrap_c;
    logic   v_wrap_c;
    phase_t h_phase_nxt_c;
    phase_t v_phase_nxt_c;

    // The first edge after reset presents (0,0) without advancing the counters
    always_ff @(posedge clk) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= 1'b1;
    end

    vga_axis_timer #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (HCNT_W)
    ) u_h_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (run_q),
        .count       (hcounter),
        .phase_nxt_c (h_phase_nxt_c),
        .wrap_c      (h_wrap_c)
    );

    vga_axis_timer #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (VCNT_W)
    ) u_v_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (h_wrap_c),
        .count       (vcounter),
        .phase_nxt_c (v_phase_nxt_c),
        .wrap_c      (v_wrap_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            visible     <= 1'b0;
            VGA_HS      <= ~SYNC_POL;
            VGA_VS      <= ~SYNC_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            visible     <= (h_phase_nxt_c == PH_ACTIVE) && (v_phase_nxt_c == PH_ACTIVE);
            VGA_HS      <= (h_phase_nxt_c == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            VGA_VS      <= (v_phase_nxt_c == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            frame_start <= ~run_q | v_wrap_c;
            line_start  <= ~run_q | h_wrap_c;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instances for line timing (both polarities)
// and a shrunken-timing instance for whole-frame, double-wrap and reset cases.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // default timing, active-high sync
    logic [11:0] d_h;
    logic [10:0] d_v;
    logic        d_vis, d_hs, d_vs, d_fs, d_ls;
    // default timing, active-low sync
    logic [11:0] n_h;
    logic [10:0] n_v;
    logic        n_vis, n_hs, n_vs, n_fs, n_ls;
    // small timing: H 8/2/3/3 (16), V 4/1/2/1 (8), frame 128 cycles
    logic [11:0] s_h;
    logic [10:0] s_v;
    logic        s_vis, s_hs, s_vs, s_fs, s_ls;

    vga_sync_gen u_def (
        .clk(clk), .rst(rst), .hcounter(d_h), .vcounter(d_v), .visible(d_vis),
        .VGA_HS(d_hs), .VGA_VS(d_vs), .frame_start(d_fs), .line_start(d_ls)
    );

    vga_sync_gen #(.SYNC_POL(1'b0)) u_neg (
        .clk(clk), .rst(rst), .hcounter(n_h), .vcounter(n_v), .visible(n_vis),
        .VGA_HS(n_hs), .VGA_VS(n_vs), .frame_start(n_fs), .line_start(n_ls)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst(rst), .hcounter(s_h), .vcounter(s_v), .visible(s_vis),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .frame_start(s_fs), .line_start(s_ls)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [28:0] obs, exp;
        rst = 1'b1;
        repeat (3) tick();
        obs = {d_h, d_v, d_vis, d_hs, d_vs, d_fs, d_ls};
        exp = {12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_def: got %h expected %h", obs, exp);
        end
        checks++;
        if ({n_h, n_v, n_vis, n_hs, n_vs} !== {12'd0, 11'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_neg: h=%0d v=%0d vis=%b hs=%b vs=%b expected 0 0 0 1 1",
                     n_h, n_v, n_vis, n_hs, n_vs);
        end
        rst = 1'b0;
        tick();
        obs = {d_h, d_v, d_vis, d_hs, d_vs, d_fs, d_ls};
        exp = {12'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL release_cycle0: got %h expected %h", obs, exp);
        end
        repeat (1040) tick();
        obs = {d_h, d_v, d_vis, d_hs, d_vs, d_fs, d_ls};
        exp = {12'd0, 11'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL release_line1: got %h expected %h", obs, exp);
        end
    endtask

    // Line 0 of the default timing, checked cycle by cycle for both polarities
    task automatic test_line_timing();
        int vis_cnt = 0;
        int hs_cnt  = 0;
        int nhs_low = 0;
        logic e_vis, e_hs;
        restart();
        for (int i = 0; i < 1040; i++) begin
            e_vis = (i < 800);
            e_hs  = (i >= 856) && (i <= 975);
            checks++;
            if ({d_h, d_v, d_vis, d_hs, d_vs, d_ls} !== {12'(i), 11'd0, e_vis, e_hs, 1'b0, (i == 0)}) begin
                errors++;
                $display("FAIL line_def i=%0d: h=%0d v=%0d vis=%b hs=%b vs=%b ls=%b expected vis=%b hs=%b",
                         i, d_h, d_v, d_vis, d_hs, d_vs, d_ls, e_vis, e_hs);
            end
            checks++;
            if ({n_h, n_vis, n_hs, n_vs} !== {12'(i), e_vis, ~e_hs, 1'b1}) begin
                errors++;
                $display("FAIL line_neg i=%0d: h=%0d vis=%b hs=%b vs=%b expected hs=%b vs=1",
                         i, n_h, n_vis, n_hs, n_vs, ~e_hs);
            end
            if (d_vis === 1'b1) vis_cnt++;
            if (d_hs === 1'b1)  hs_cnt++;
            if (n_hs === 1'b0)  nhs_low++;
            tick();
        end
        checks++;
        if (vis_cnt != 800 || hs_cnt != 120 || nhs_low != 120) begin
            errors++;
            $display("FAIL line_counts: vis=%0d hs=%0d nhs_low=%0d expected 800 120 120",
                     vis_cnt, hs_cnt, nhs_low);
        end
        checks++;
        if ({d_h, d_v, d_ls, d_fs} !== {12'd0, 11'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL line_period: h=%0d v=%0d ls=%b fs=%b expected 0 1 1 0",
                     d_h, d_v, d_ls, d_fs);
        end
    endtask

    // Two full small frames including the double wrap at (15,7)
    task automatic test_frame();
        int eh, ev, last_fs, fs_cnt;
        logic [28:0] obs, exp;
        last_fs = -1;
        fs_cnt  = 0;
        restart();
        for (int i = 0; i < 256; i++) begin
            eh = i % 16;
            ev = (i / 16) % 8;
            obs = {s_h, s_v, s_vis, s_hs, s_vs, s_fs, s_ls};
            exp = {12'(eh), 11'(ev), (eh < 8) && (ev < 4), (eh >= 10) && (eh <= 12),
                   (ev >= 5) && (ev <= 6), (eh == 0) && (ev == 0), (eh == 0)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL frame i=%0d: h=%0d v=%0d vis=%b hs=%b vs=%b fs=%b ls=%b expected %h",
                         i, s_h, s_v, s_vis, s_hs, s_vs, s_fs, s_ls, exp);
            end
            if (s_fs === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != 128) begin
                        errors++;
                        $display("FAIL frame_period: got %0d expected 128", i - last_fs);
                    end
                end
                last_fs = i;
                fs_cnt++;
            end
            tick();
        end
        checks++;
        if (fs_cnt != 2) begin
            errors++;
            $display("FAIL frame_pulses: got %0d expected 2", fs_cnt);
        end
        checks++;
        if ({s_h, s_v, s_fs} !== {12'd0, 11'd0, 1'b1}) begin
            errors++;
            $display("FAIL double_wrap: h=%0d v=%0d fs=%b expected 0 0 1", s_h, s_v, s_fs);
        end
    endtask

    // Reset while both syncs are active, then a clean restart
    task automatic test_mid_reset();
        restart();
        repeat (5 * 16 + 11) tick();
        checks++;
        if ({s_h, s_v, s_hs, s_vs} !== {12'd11, 11'd5, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre: h=%0d v=%0d hs=%b vs=%b expected 11 5 1 1", s_h, s_v, s_hs, s_vs);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({s_h, s_v, s_vis, s_hs, s_vs, s_fs, s_ls} !== {12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: h=%0d v=%0d vis=%b hs=%b vs=%b fs=%b ls=%b expected all 0",
                     s_h, s_v, s_vis, s_hs, s_vs, s_fs, s_ls);
        end
        checks++;
        if ({d_h, d_v, d_vis, n_hs, n_vs} !== {12'd0, 11'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_def: dh=%0d dv=%0d dvis=%b nhs=%b nvs=%b expected 0 0 0 1 1",
                     d_h, d_v, d_vis, n_hs, n_vs);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({s_h, s_v, s_vis, s_fs, s_ls} !== {12'd0, 11'd0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_release: h=%0d v=%0d vis=%b fs=%b ls=%b expected 0 0 1 1 1",
                     s_h, s_v, s_vis, s_fs, s_ls);
        end
        tick();
        checks++;
        if ({s_h, s_v, s_fs, s_ls} !== {12'd1, 11'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_advance: h=%0d v=%0d fs=%b ls=%b expected 1 0 0 0",
                     s_h, s_v, s_fs, s_ls);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The module SHALL use these parameters (name, default, meaning): H_ACTIVE 800 visible pixels/line; H_FP 56 front porch; H_SYNC 120 sync width; H_BP 64 back porch; V_ACTIVE 600 visible lines; V_FP 37; V_SYNC 6; V_BP 23; SYNC_POL 1 (1 = active-high sync pulse).
REQ-002 The ports SHALL be (name, direction, width, meaning): clk, input, 1, pixel clock (50 MHz for the defaults, 800x600@72).
REQ-003 rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 hcounter, output, 12, current pixel column, 0..H_TOTAL-1.
REQ-005 vcounter, output, 11, current line, 0..V_TOTAL-1.
REQ-006 visible, output, 1, high when the current pixel lies in the active area.
REQ-007 VGA_HS, output, 1, horizontal sync, polarity per SYNC_POL.
REQ-008 VGA_VS, output, 1, vertical sync, polarity per SYNC_POL.
REQ-009 frame_start, output, 1, one-cycle pulse while hcounter==0 and vcounter==0.
REQ-010 line_start, output, 1, one-cycle pulse while hcounter==0.

Function
REQ-011 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (1040); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (666).
REQ-012 hcounter SHALL increment by 1 every clk; at H_TOTAL-1 it SHALL wrap to 0 on the next cycle.
REQ-013 vcounter SHALL increment only on the cycle hcounter wraps; at V_TOTAL-1 with a simultaneous hcounter wrap, it SHALL wrap to 0, with both counters becoming 0 in the same cycle.
REQ-014 Each axis SHALL carry a 4-state phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE; the phase transition SHALL occur on the same clock edge as the counter crossing the phase boundary.
REQ-015 H phase boundaries: ACTIVE 0..799, FRONT 800..855, SYNC 856..975, BACK 976..1039; V: ACTIVE 0..599, FRONT 600..636, SYNC 637..642, BACK 643..665.
REQ-016 All outputs SHALL be registered and mutually aligned: each output describes the same (hcounter, vcounter) pair in the same cycle, with zero relative latency.
REQ-017 visible SHALL equal (H phase==ACTIVE) AND (V phase==ACTIVE).
REQ-018 VGA_HS SHALL be SYNC_POL while H phase==SYNC and ~SYNC_POL otherwise; VGA_VS likewise for V phase==SYNC, for every hcounter value of those lines.
REQ-019 Counter arithmetic SHALL be unsigned; no counter SHALL exceed TOTAL-1 under any sequence.

Reset
REQ-020 While rst is high at a clk edge: hcounter=0, vcounter=0, both FSMs=ACTIVE, visible=0, VGA_HS=VGA_VS=~SYNC_POL, frame_start=0, line_start=0.
REQ-021 First cycle after rst deasserts: hcounter=0, vcounter=0, visible=1, frame_start=1, line_start=1.
REQ-022 rst asserted mid-frame (any phase, including during sync) SHALL apply REQ-020 on that edge, with no partial-line completion.

Structure
REQ-023 The default timing constants, H_TOTAL/V_TOTAL and the phase enumeration (ACTIVE, FRONT, SYNC, BACK) SHALL reside in the shared package vga_pkg, for use by the drawing blocks.
REQ-024 One sub-module, vga_axis_timer (counter + phase FSM + wrap output, parameterised by the four segment lengths), SHALL be instantiated twice: horizontal with enable=1, vertical with enable=horizontal wrap.

Verification
REQ-025 Reset release: hold rst 3 cycles, release -> cycle 0: h=0,v=0,visible=1,frame_start=1; after 1040 cycles h=0,v=1,line_start=1,frame_start=0.
REQ-026 Line timing: count cycles on line 0 -> visible high exactly 800 cycles (h 0..799); VGA_HS high exactly at h 856..975 (120 cycles); line period 1040.
REQ-027 Frame timing: run 2 frames -> frame_start period 692640 cycles; VGA_VS high during lines 637..642 (6240 cycles); visible=0 for all of v 600..665.
REQ-028 Double wrap: at h=1039,v=665 -> next cycle h=0,v=0,frame_start=1; vcounter never reads 666.
REQ-029 Mid-operation reset: assert rst at h=900,v=640 (both syncs active) -> next edge VGA_HS=VGA_VS=0, h=0,v=0,visible=0; after release, frame restarts per REQ-025.
REQ-030 SYNC_POL=0 build: repeat REQ-026 -> VGA_HS low exactly at h 856..975, high elsewhere and during reset.
